// File: rtl/score_display_driver.sv
// Binary score to BCD (sequential double-dabble) with a time-multiplexed, active-low
// 7-segment scanner. Leading zeros are blanked; values too wide for the display saturate to 9s.
module score_display_driver #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 1000
) (
    input  logic                  clock_div,
    input  logic                  reset,
    input  logic [31:0]           score,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  busy,
    output logic                  overflow
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

    state_t                      state_q;
    logic [31:0]                 shown_bin_q, bin_sr_q, cap_q;
    logic [39:0]                 bcd_q;
    logic [4:0]                  bit_cnt_q;
    logic [NUM_DIGITS-1:0][3:0]  disp_q, disp_d;
    logic                        busy_q, overflow_q, sat_d;
    logic [35:0]                 bcd_adj_d;
    logic [IDX_W-1:0]            scan_idx_q;
    logic [CNT_W-1:0]            refresh_cnt_q;
    logic [NUM_DIGITS-1:0]       an_q, an_d;
    logic [6:0]                  seg_q, seg_d;
    logic                        blank_d;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0: decode = 7'b1000000;
            4'd1: decode = 7'b1111001;
            4'd2: decode = 7'b0100100;
            4'd3: decode = 7'b0110000;
            4'd4: decode = 7'b0011001;
            4'd5: decode = 7'b0010010;
            4'd6: decode = 7'b0000010;
            4'd7: decode = 7'b1111000;
            4'd8: decode = 7'b0000000;
            4'd9: decode = 7'b0010000;
            default: decode = 7'h7F;
        endcase
    endfunction

    // The top BCD digit of a 32-bit value never reaches 5 mid-conversion, so only
    // nibbles 0..8 need the add-3 correction.
    always_comb begin
        bcd_adj_d = bcd_q[35:0];
        for (int i = 0; i < 9; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        sat_d = 1'b0;
        for (int i = NUM_DIGITS; i < 10; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) sat_d = 1'b1;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            disp_d[i] = sat_d ? 4'd9 : bcd_q[4*i +: 4];
        end
    end

    // NOTE: all state below updates with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock_div or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            shown_bin_q <= '0;
            bin_sr_q    <= '0;
            cap_q       <= '0;
            bcd_q       <= '0;
            bit_cnt_q   <= '0;
            disp_q      <= '0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (score != shown_bin_q) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    bin_sr_q  <= score;
                    cap_q     <= score;
                    bcd_q     <= '0;
                    bit_cnt_q <= '0;
                    busy_q    <= 1'b1;
                    state_q   <= S_SHIFT;
                end
                S_SHIFT: begin
                    bcd_q     <= {bcd_q[38:36], bcd_adj_d, bin_sr_q[31]};
                    bin_sr_q  <= {bin_sr_q[30:0], 1'b0};
                    bit_cnt_q <= bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd31) state_q <= S_DONE;
                end
                S_DONE: begin
                    disp_q      <= disp_d;
                    shown_bin_q <= cap_q;
                    overflow_q  <= sat_d;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Digit i>0 is blank when it and every more significant digit are zero.
    always_comb begin
        blank_d = (scan_idx_q != '0) && !overflow_q;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= int'(scan_idx_q) && disp_q[j] != 4'd0) blank_d = 1'b0;
        end
        seg_d = blank_d ? 7'h7F : decode(disp_q[scan_idx_q]);
        an_d  = ~(NUM_DIGITS'(1) << scan_idx_q);
    end

    always_ff @(posedge clock_div or posedge reset) begin
        if (reset) begin
            scan_idx_q    <= '0;
            refresh_cnt_q <= '0;
            an_q          <= '1;
            seg_q         <= 7'h7F;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            if (refresh_cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
                refresh_cnt_q <= '0;
                scan_idx_q    <= (scan_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + IDX_W'(1);
            end else begin
                refresh_cnt_q <= refresh_cnt_q + CNT_W'(1);
            end
        end
    end

    assign seg      = seg_q;
    assign an       = an_q;
    assign dp       = 1'b1;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule
